// File: rtl/booth_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mul_arbiter
//  Description : Round-robin arbiter/sequencer sharing one multi-cycle
//                multiplier between NREQ requesters. Accepts one operand
//                pair at a time, issues it, waits for done (bounded by a
//                watchdog) and returns the product over a held response.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH_M = 8,
   parameter int WIDTH_R = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [NREQ-1:0]            req_vld,
   output logic [NREQ-1:0]            req_rdy,
   input  logic [NREQ*WIDTH_M-1:0]    req_a,
   input  logic [NREQ*WIDTH_R-1:0]    req_b,
   output logic [NREQ-1:0]            rsp_vld,
   input  logic [NREQ-1:0]            rsp_rdy,
   output logic [WIDTH_M+WIDTH_R-1:0] rsp_data,
   output logic                       rsp_err,
   output logic                       mul_vld,
   output logic [WIDTH_M-1:0]         mul_a,
   output logic [WIDTH_R-1:0]         mul_b,
   input  logic [WIDTH_M+WIDTH_R-1:0] mul_out,
   input  logic                       mul_done,
   output logic                       busy
);

   localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int c_WP = WIDTH_M + WIDTH_R;
   // Counter only needs to reach TIMEOUT-1
   localparam int c_CW = $clog2(TIMEOUT);
   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);
   localparam logic [c_PW-1:0] c_OWN_LAST = c_PW'(NREQ - 1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ISSUE = 2'd1;
   localparam logic [1:0] c_WAIT  = 2'd2;
   localparam logic [1:0] c_RESP  = 2'd3;

   logic [1:0]         r_state;
   logic [1:0]         w_next;
   logic [c_PW-1:0]    r_ptr;
   logic [c_PW-1:0]    r_owner;
   logic [c_CW-1:0]    r_cnt;
   logic [WIDTH_M-1:0] r_mul_a;
   logic [WIDTH_R-1:0] r_mul_b;
   logic [c_WP-1:0]    r_rsp_data;
   logic               r_rsp_err;
   logic               r_busy;

   logic               w_found;
   logic [c_PW-1:0]    w_win;
   logic [c_PW-1:0]    w_sel;
   logic [WIDTH_M-1:0] w_op_a;
   logic [WIDTH_R-1:0] w_op_b;
   logic               w_timeout;

   assign w_timeout = (r_cnt == c_CNT_LAST);

   // Round-robin search: first valid requester at or above the pointer, wrapping
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sel   = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_sel = c_PW'((32'(r_ptr) + 32'(k)) % 32'(NREQ));
         if (!w_found && req_vld[w_sel]) begin
            w_found = 1'b1;
            w_win   = w_sel;
         end
      end
   end

   // Operand mux for the current winner
   always_comb begin
      w_op_a = '0;
      w_op_b = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_win == c_PW'(k)) begin
            w_op_a = req_a[k*WIDTH_M +: WIDTH_M];
            w_op_b = req_b[k*WIDTH_R +: WIDTH_R];
         end
      end
   end

   // State register; busy is registered from the next state so it tracks the state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= c_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != c_IDLE);
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:  if (w_found) w_next = c_ISSUE;
         c_ISSUE: w_next = c_WAIT;
         c_WAIT:  if (mul_done || w_timeout) w_next = c_RESP;
         c_RESP:  if (rsp_rdy[r_owner]) w_next = c_IDLE;
         default: w_next = c_IDLE;
      endcase
   end

   // Datapath: operand capture, owner/pointer, watchdog and response registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ptr      <= '0;
         r_owner    <= '0;
         r_cnt      <= '0;
         r_mul_a    <= '0;
         r_mul_b    <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_found) begin
                  r_owner <= w_win;
                  r_ptr   <= (w_win == c_OWN_LAST) ? '0 : w_win + c_PW'(1);
                  r_mul_a <= w_op_a;
                  r_mul_b <= w_op_b;
               end
            end
            c_ISSUE: r_cnt <= '0;
            c_WAIT: begin
               if (mul_done) begin
                  r_rsp_data <= mul_out;
                  r_rsp_err  <= 1'b0;
               end else if (w_timeout) begin
                  r_rsp_data <= '0;
                  r_rsp_err  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + c_CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode; req_rdy is masked by rstn so it is zero while reset is held
   always_comb begin
      req_rdy = '0;
      rsp_vld = '0;
      mul_vld = 1'b0;
      case (r_state)
         c_IDLE:  if (w_found && rstn) req_rdy[w_win] = 1'b1;
         c_ISSUE: mul_vld = 1'b1;
         c_RESP:  rsp_vld[r_owner] = 1'b1;
         default: ;
      endcase
   end

   assign mul_a    = r_mul_a;
   assign mul_b    = r_mul_b;
   assign rsp_data = r_rsp_data;
   assign rsp_err  = r_rsp_err;
   assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_mul_arbiter
//  Description : Directed bench for booth_mul_arbiter with a transaction-level
//                reference model and a simple latency-programmable multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mul_arbiter;

   localparam int NREQ = 4;
   localparam int WM   = 8;
   localparam int WR   = 8;
   localparam int TO   = 64;

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic [NREQ-1:0]     req_vld = '0;
   logic [NREQ-1:0]     req_rdy;
   logic [NREQ*WM-1:0]  req_a = '0;
   logic [NREQ*WR-1:0]  req_b = '0;
   logic [NREQ-1:0]     rsp_vld;
   logic [NREQ-1:0]     rsp_rdy = '1;
   logic [WM+WR-1:0]    rsp_data;
   logic                rsp_err;
   logic                mul_vld;
   logic [WM-1:0]       mul_a;
   logic [WR-1:0]       mul_b;
   logic [WM+WR-1:0]    mul_out;
   logic                mul_done;
   logic                busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   booth_mul_arbiter #(.NREQ(NREQ), .WIDTH_M(WM), .WIDTH_R(WR), .TIMEOUT(TO)) dut (
      .clk(clk), .rstn(rstn),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mul_vld(mul_vld), .mul_a(mul_a), .mul_b(mul_b),
      .mul_out(mul_out), .mul_done(mul_done), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- multiplier stand-in ----------------
   int          mm_lat = 3;
   bit          mm_never = 1'b0;
   bit          stray_done = 1'b0;
   int          mm_cnt = 0;
   logic [15:0] mm_prod = '0;

   always @(posedge clk) begin
      if (mul_vld) begin
         mm_cnt  <= mm_lat;
         mm_prod <= mul_a * mul_b;
      end else if (mm_cnt > 0) begin
         mm_cnt <= mm_cnt - 1;
      end
   end
   assign mul_done = ((mm_cnt == 1) && !mm_never) || stray_done;
   assign mul_out  = mm_prod;

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic bound_fail(input string nm, input int budget);
      n_tests++;
      n_fail++;
      $display("FAIL %s: no event within %0d cycles (cycle %0d)", nm, budget, cyc);
   endtask

   function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int p);
      logic [NREQ-1:0] g;
      int i;
      g = '0;
      for (int k = 0; k < NREQ; k++) begin
         i = (p + k) % NREQ;
         if (g == '0 && v[i]) g[i] = 1'b1;
      end
      return g;
   endfunction

   // ---------------- transaction-level reference model ----------------
   // One outstanding transaction; m_age counts cycles since the accept.
   bit          m_busy = 1'b0;
   bit          m_resp = 1'b0;
   bit          m_err  = 1'b0;
   int          m_owner = 0;
   int          m_ptr = 0;
   int          m_age = 0;
   logic [7:0]  m_a = '0;
   logic [7:0]  m_b = '0;
   logic [15:0] m_data = '0;

   initial begin : compare
      logic [NREQ-1:0] g;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            m_busy = 1'b0; m_resp = 1'b0; m_err = 1'b0;
            m_ptr = 0; m_a = '0; m_b = '0; m_data = '0;
         end else begin
            g = m_busy ? '0 : rr_pick(req_vld, m_ptr);
            chk("m_req_rdy", req_rdy, g);
            chk("m_mul_vld", mul_vld, (m_busy && m_age == 1));
            chk("m_rsp_vld", rsp_vld, (m_busy && m_resp) ? (1 << m_owner) : 0);
            chk("m_busy", busy, m_busy);
            chk("m_mul_a", mul_a, m_a);
            chk("m_mul_b", mul_b, m_b);
            if (m_busy && m_resp) begin
               chk("m_rsp_data", rsp_data, m_data);
               chk("m_rsp_err", rsp_err, m_err);
            end
            if (!m_busy) begin
               if (g != '0) begin
                  for (int k = 0; k < NREQ; k++) if (g[k]) m_owner = k;
                  m_a    = req_a[m_owner*WM +: WM];
                  m_b    = req_b[m_owner*WR +: WR];
                  m_ptr  = (m_owner + 1) % NREQ;
                  m_busy = 1'b1;
                  m_resp = 1'b0;
                  m_age  = 1;
               end
            end else begin
               if (m_resp) begin
                  if (rsp_rdy[m_owner]) begin
                     m_busy = 1'b0;
                     m_resp = 1'b0;
                  end
               end else if (m_age >= 2) begin
                  if (mul_done) begin
                     m_resp = 1'b1; m_err = 1'b0;
                     m_data = 16'(m_a) * 16'(m_b);
                  end else if (m_age == TO + 1) begin
                     m_resp = 1'b1; m_err = 1'b1; m_data = '0;
                  end
               end
               m_age++;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   int grants[$];
   int gcyc[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int i, input logic [7:0] a, input logic [7:0] b, output int t_acc);
      bit ok;
      ok = 1'b0;
      req_a[i*WM +: WM] = a;
      req_b[i*WR +: WR] = b;
      req_vld[i] = 1'b1;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         if (req_rdy[i]) ok = 1'b1;
      end
      if (!ok) bound_fail("send_grant", 50);
      t_acc = cyc;
      tick();
      req_vld[i] = 1'b0;
   endtask

   task automatic wait_rsp(input int budget);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         if (rsp_vld != '0) ok = 1'b1;
      end
      if (!ok) bound_fail("wait_rsp", budget);
   endtask

   task automatic wait_idle(input int budget);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         if (!busy) ok = 1'b1;
      end
      if (!ok) bound_fail("wait_idle", budget);
      tick();
   endtask

   task automatic collect(input int n, input bit drop, input int budget);
      int c;
      c = 0;
      grants.delete();
      gcyc.delete();
      while (grants.size() < n && c < budget) begin
         @(negedge clk);
         c++;
         chk("rdy_onehot", ($countones(req_rdy) > 1), 0);
         for (int k = 0; k < NREQ; k++)
            if (req_vld[k] && req_rdy[k]) begin
               grants.push_back(k);
               gcyc.push_back(cyc);
            end
         if (drop && grants.size() > 0 && gcyc[$] == cyc) begin
            tick();
            req_vld[grants[$]] = 1'b0;
         end
      end
      if (grants.size() < n) bound_fail("collect", budget);
      tick();
   endtask

   task automatic reset_pulse();
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin : main
      int t0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_rsp_vld", rsp_vld, 0);
      chk("rst_mul_vld", mul_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
      tick();
      rstn = 1'b1;

      // Single request, requester 0
      mm_lat = 3;
      send(0, 8'h12, 8'h34, t0);
      @(negedge clk);
      chk("t1_mul_vld_T1", mul_vld, 1);
      chk("t1_mul_a", mul_a, 8'h12);
      chk("t1_mul_b", mul_b, 8'h34);
      @(negedge clk);
      chk("t1_mul_vld_T2", mul_vld, 0);
      wait_rsp(20);
      chk("t1_rsp_vld", rsp_vld, 4'b0001);
      chk("t1_rsp_data", rsp_data, 16'h03A8);
      chk("t1_rsp_err", rsp_err, 0);
      chk("t1_latency", cyc - t0, 5);
      tick();

      // Product check, requester 2, minimum latency
      mm_lat = 1;
      send(2, 8'hAB, 8'hCD, t0);
      wait_rsp(20);
      chk("t2_rsp_vld", rsp_vld, 4'b0100);
      chk("t2_rsp_data", rsp_data, 16'h88EF);
      chk("t2_latency", cyc - t0, 3);
      tick();

      // Fairness: all four held high from reset
      reset_pulse();
      req_a = {8'h00, 8'h13, 8'h12, 8'h11};
      req_b = {8'h07, 8'h05, 8'h04, 8'h03};
      req_vld = '1;
      collect(6, 1'b0, 100);
      req_vld = '0;
      if (grants.size() >= 6) begin
         chk("fair_g0", grants[0], 0);
         chk("fair_g1", grants[1], 1);
         chk("fair_g2", grants[2], 2);
         chk("fair_g3", grants[3], 3);
         chk("fair_g4", grants[4], 0);
         chk("fair_g5", grants[5], 1);
         chk("fair_spacing", gcyc[1] - gcyc[0], 4);
      end
      wait_idle(40);

      // Requesters 3 and 1 together after reset: 1 first
      reset_pulse();
      req_vld = 4'b1010;
      collect(2, 1'b1, 60);
      if (grants.size() >= 2) begin
         chk("pair_first", grants[0], 1);
         chk("pair_second", grants[1], 3);
      end
      wait_idle(40);

      // Response backpressure on requester 1 with requester 0 waiting
      mm_lat = 2;
      rsp_rdy = 4'b1101;
      send(1, 8'h05, 8'h07, t0);
      req_a[0*WM +: WM] = 8'h21;
      req_b[0*WR +: WR] = 8'h02;
      req_vld[0] = 1'b1;
      wait_rsp(20);
      chk("bp_rsp_data0", rsp_data, 16'h0023);
      repeat (5) begin
         @(negedge clk);
         chk("bp_rsp_vld", rsp_vld, 4'b0010);
         chk("bp_rsp_data", rsp_data, 16'h0023);
         chk("bp_req_rdy", req_rdy, 0);
         chk("bp_mul_vld", mul_vld, 0);
      end
      tick();
      rsp_rdy = '1;
      collect(1, 1'b1, 20);
      if (grants.size() >= 1) chk("bp_next_grant", grants[0], 0);
      wait_rsp(20);
      chk("bp_next_rsp_vld", rsp_vld, 4'b0001);
      chk("bp_next_rsp_data", rsp_data, 16'h0042);
      tick();

      // Timeout: multiplier never completes
      mm_never = 1'b1;
      send(2, 8'h03, 8'h04, t0);
      wait_rsp(100);
      chk("to_latency", cyc - t0, 66);
      chk("to_rsp_vld", rsp_vld, 4'b0100);
      chk("to_rsp_err", rsp_err, 1);
      chk("to_rsp_data", rsp_data, 0);
      tick();
      mm_never = 1'b0;
      tick();
      stray_done = 1'b1;
      tick();
      stray_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stray_busy", busy, 0);
         chk("stray_rsp_vld", rsp_vld, 0);
      end
      tick();

      // Reset in the middle of WAIT
      mm_lat = 20;
      send(1, 8'h09, 8'h09, t0);
      repeat (3) tick();
      rstn = 1'b0;
      #1;
      chk("mr_busy", busy, 0);
      chk("mr_mul_vld", mul_vld, 0);
      chk("mr_req_rdy", req_rdy, 0);
      chk("mr_rsp_vld", rsp_vld, 0);
      chk("mr_mul_a", mul_a, 0);
      chk("mr_mul_b", mul_b, 0);
      chk("mr_rsp_data", rsp_data, 0);
      chk("mr_rsp_err", rsp_err, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      mm_lat = 2;
      req_a[0*WM +: WM] = 8'h0F;
      req_b[0*WR +: WR] = 8'h11;
      req_a[2*WM +: WM] = 8'h02;
      req_b[2*WR +: WR] = 8'h03;
      req_vld = 4'b0101;
      collect(2, 1'b1, 60);
      if (grants.size() >= 2) begin
         chk("mr_first", grants[0], 0);
         chk("mr_second", grants[1], 2);
      end
      wait_idle(40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
